// File: rtl/message_scroll_ctrl_if.sv
// message_scroll_ctrl_if: request/abort inputs and display outputs
// of the scrolling message controller.
interface message_scroll_ctrl_if #(
  parameter int DIGITS = 4
);
  logic              start;
  logic              pass;
  logic [1:0]        loops;
  logic              stop;
  logic [2:0]        letter;
  logic [DIGITS-1:0] digit_en;
  logic              busy;
  logic              done;

  modport master (
    output start, pass, loops, stop,
    input  letter, digit_en, busy, done
  );

  modport slave (
    input  start, pass, loops, stop,
    output letter, digit_en, busy, done
  );
endinterface

// File: rtl/message_scroll_ctrl.sv
// message_scroll_ctrl: scrolls SUCCESS or ERROR across a multiplexed
// seven-segment display, with blank lead-in and lead-out.
module message_scroll_ctrl #(
  parameter int DIGITS     = 4,
  parameter int MUX_DIV    = 4,
  parameter int SCROLL_DIV = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  message_scroll_ctrl_if.slave bus
);

  localparam int LMAX = 7;
  localparam int PW   = $clog2(LMAX + DIGITS + 1);
  localparam int KW   = $clog2(LMAX + 2 * DIGITS);
  localparam int DW   = $clog2(DIGITS);
  localparam int MW   = $clog2(MUX_DIV + 1);
  localparam int SW   = $clog2(SCROLL_DIV + 1);

  localparam logic [DW-1:0] DLAST  = DW'(DIGITS - 1);
  localparam logic [MW-1:0] MLAST  = MW'(MUX_DIV - 1);
  localparam logic [SW-1:0] SLAST  = SW'(SCROLL_DIV - 1);
  localparam logic [PW-1:0] PEND_S = PW'(7 + DIGITS);
  localparam logic [PW-1:0] PEND_E = PW'(5 + DIGITS);
  localparam logic [KW-1:0] KD     = KW'(DIGITS);
  localparam logic [2:0]    BLANK  = 3'd6;

  typedef enum logic {
    IDLE,
    SCROLL
  } state_t;

  state_t        state_q, state_d;
  logic          pass_q, pass_d;
  logic [1:0]    rem_q, rem_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [MW-1:0] mc_q, mc_d;
  logic [SW-1:0] sc_q, sc_d;
  logic          done_q, done_d;

  logic          mux_tick;
  logic          step_tick;
  logic          at_end;
  logic [KW-1:0] kidx;

  // Code at position k of the blank-padded virtual sequence.
  function automatic logic [2:0] seq_code(
    input logic          p,
    input logic [KW-1:0] k
  );
    logic [KW-1:0] j;
    seq_code = BLANK;
    j = k - KD;
    if (k >= KD) begin
      if (p) begin
        case (j)
          KW'(0):  seq_code = 3'd3;
          KW'(1):  seq_code = 3'd4;
          KW'(2):  seq_code = 3'd5;
          KW'(3):  seq_code = 3'd5;
          KW'(4):  seq_code = 3'd0;
          KW'(5):  seq_code = 3'd3;
          KW'(6):  seq_code = 3'd3;
          default: seq_code = BLANK;
        endcase
      end else begin
        case (j)
          KW'(0):  seq_code = 3'd0;
          KW'(1):  seq_code = 3'd1;
          KW'(2):  seq_code = 3'd1;
          KW'(3):  seq_code = 3'd2;
          KW'(4):  seq_code = 3'd1;
          default: seq_code = BLANK;
        endcase
      end
    end
  endfunction

  assign mux_tick  = (mc_q == MLAST);
  assign step_tick = (sc_q == SLAST);
  assign at_end    = (pos_q == (pass_q ? PEND_S : PEND_E));
  assign kidx      = KW'(pos_q) + KW'(dig_q);

  // Register all controller state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
      rem_q   <= '0;
      pos_q   <= '0;
      dig_q   <= '0;
      mc_q    <= '0;
      sc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      dig_q   <= dig_d;
      mc_q    <= mc_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
    end
  end

  // Next state: start latch, abort, digit refresh, scroll and pass end.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    dig_d   = dig_q;
    mc_d    = mc_q;
    sc_d    = sc_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCROLL;
          pass_d  = bus.pass;
          rem_d   = bus.loops;
          pos_d   = '0;
          dig_d   = '0;
          mc_d    = '0;
          sc_d    = '0;
        end
      end
      SCROLL: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          if (mux_tick) begin
            mc_d  = '0;
            dig_d = (dig_q == DLAST) ? '0 : dig_q + 1'b1;
          end else begin
            mc_d = mc_q + 1'b1;
          end
          if (step_tick) begin
            sc_d = '0;
            if (!at_end) begin
              pos_d = pos_q + 1'b1;
            end else if (rem_q == 2'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              pos_d = '0;
              if (rem_q != 2'd0) begin
                rem_d = rem_q - 2'd1;
              end
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display outputs decoded from registered state only.
  always_comb begin
    bus.letter   = BLANK;
    bus.digit_en = '1;
    bus.busy     = 1'b0;
    bus.done     = done_q;
    if (state_q == SCROLL) begin
      bus.letter   = seq_code(pass_q, kidx);
      bus.digit_en = ~(DIGITS'(1) << dig_q);
      bus.busy     = 1'b1;
    end
  end

endmodule
